// File: rtl/font_rom_arbiter_pkg.sv
// Shared font ROM types and widths.
// Used by the font ROM arbiter and its tag pipeline.
package font_rom_arbiter_pkg;

  localparam int FONT_ADDR_W = 11;
  localparam int FONT_DATA_W = 8;

  localparam logic [3:0] WAIT_SAT = 4'd15;

  // One in-flight ROM read: whether it exists and which port issued it.
  typedef struct packed {
    logic valid;
    logic id;
  } font_tag_t;

endpackage

// File: rtl/font_rom_arbiter_font_tag_pipe.sv
// Delay line of read tags, aligned with the ROM output.
// Reset clears all in-flight tags so discarded reads never return.
module font_tag_pipe
  import font_rom_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  font_tag_t i_tag,
  output font_tag_t o_tag
);

  font_tag_t r_pipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/font_rom_arbiter.sv
// Two-port arbiter in front of the synchronous font ROM: port 0 has priority,
// port 1 is forced through after MAX_WAIT denied cycles.
module font_rom_arbiter
  import font_rom_arbiter_pkg::*;
#(
  parameter int ADDR_W   = FONT_ADDR_W,
  parameter int DATA_W   = FONT_DATA_W,
  parameter int ROM_LAT  = 1,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  logic [3:0] r_wait_cnt;
  logic       w_force1;
  font_tag_t  w_tag_in;
  font_tag_t  w_tag_out;

  assign w_force1 = req1 && (r_wait_cnt >= 4'(MAX_WAIT));

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (w_force1)  gnt1 = 1'b1;
    else if (req0) gnt0 = 1'b1;
    else if (req1) gnt1 = 1'b1;
  end

  // Counts consecutive cycles port 1 has been kept waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_wait_cnt <= '0;
    else if (!req1 || gnt1)      r_wait_cnt <= '0;
    else if (r_wait_cnt != WAIT_SAT) r_wait_cnt <= r_wait_cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rom_addr <= '0;
    else if (gnt0) rom_addr <= addr0;
    else if (gnt1) rom_addr <= addr1;
  end

  assign w_tag_in = '{valid: gnt0 | gnt1, id: gnt1};

  // One stage per ROM latency edge plus the address register.
  font_tag_pipe #(.DEPTH(ROM_LAT + 1)) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= w_tag_out.valid && !w_tag_out.id;
      rvalid1 <= w_tag_out.valid &&  w_tag_out.id;
      if (w_tag_out.valid && !w_tag_out.id) rdata0 <= rom_data;
      if (w_tag_out.valid &&  w_tag_out.id) rdata1 <= rom_data;
    end
  end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Self-checking bench: table vectors, directed corner cases and random traffic
// against a cycle-indexed scoreboard of expected read returns.
module tb_font_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // default build
  logic        req0, req1, gnt0, gnt1, rvalid0, rvalid1;
  logic [10:0] addr0, addr1, rom_addr;
  logic [7:0]  rdata0, rdata1, rom_data;
  // ROM_LAT=4 build
  logic        b_req0, b_req1, b_gnt0, b_gnt1, b_rvalid0, b_rvalid1;
  logic [10:0] b_addr0, b_addr1, b_rom_addr;
  logic [7:0]  b_rdata0, b_rdata1, b_rom_data;

  font_rom_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  font_rom_arbiter #(.ROM_LAT(4)) dut_b (
    .clk(clk), .rst(rst),
    .req0(b_req0), .addr0(b_addr0), .gnt0(b_gnt0), .rvalid0(b_rvalid0), .rdata0(b_rdata0),
    .req1(b_req1), .addr1(b_addr1), .gnt1(b_gnt1), .rvalid1(b_rvalid1), .rdata1(b_rdata1),
    .rom_addr(b_rom_addr), .rom_data(b_rom_data)
  );

  function automatic logic [7:0] romf(input logic [10:0] a);
    if (a == 11'h410) return 8'h18;
    return a[7:0] ^ {a[10:8], a[10:8], 2'b01};
  endfunction

  // Behavioural synchronous ROMs of latency 1 and 4
  logic [7:0] b_p [4];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_data <= '0;
      for (int i = 0; i < 4; i++) b_p[i] <= '0;
    end else begin
      rom_data <= romf(rom_addr);
      b_p[0] <= romf(b_rom_addr);
      for (int i = 1; i < 4; i++) b_p[i] <= b_p[i-1];
    end
  end
  assign b_rom_data = b_p[3];

  int nvec = 0, nerr = 0, cyc = 0, wcnt = 0;
  bit         ev0 [4096], ev1 [4096];
  logic [7:0] ed0 [4096], ed1 [4096];
  logic [7:0] m_rd0, m_rd1;
  logic [10:0] m_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // One cycle on the default build: drive, check against the model, advance the model.
  task automatic step(input logic r0, input logic [10:0] a0, input logic r1,
                      input logic [10:0] a1, output logic g0, output logic g1);
    logic f;
    @(negedge clk);
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    #1;
    f  = r1 && (wcnt >= 3);
    g1 = f || (!r0 && r1);
    g0 = !f && r0;
    chk("gnt0", gnt0, g0);
    chk("gnt1", gnt1, g1);
    chk("rom_addr", rom_addr, m_addr);
    if (ev0[cyc]) m_rd0 = ed0[cyc];
    if (ev1[cyc]) m_rd1 = ed1[cyc];
    chk("rvalid0", rvalid0, ev0[cyc]);
    chk("rvalid1", rvalid1, ev1[cyc]);
    chk("rdata0", rdata0, m_rd0);
    chk("rdata1", rdata1, m_rd1);
    if (g0) begin ev0[cyc+3] = 1'b1; ed0[cyc+3] = romf(a0); m_addr = a0; end
    if (g1) begin ev1[cyc+3] = 1'b1; ed1[cyc+3] = romf(a1); m_addr = a1; end
    if (!r1 || g1) wcnt = 0;
    else if (wcnt < 15) wcnt++;
    cyc++;
  endtask

  task automatic idle(input int n);
    logic g0, g1;
    for (int i = 0; i < n; i++) step(1'b0, 11'h0, 1'b0, 11'h0, g0, g1);
  endtask

  // Reset for one cycle; in-flight reads are forgotten by the model.
  task automatic do_reset();
    @(negedge clk);
    req0 = 0; req1 = 0; rst = 1'b1;
    #1;
    for (int i = cyc; i < 4096; i++) begin ev0[i] = 0; ev1[i] = 0; end
    m_rd0 = '0; m_rd1 = '0; m_addr = '0; wcnt = 0;
    chk("rst_rvalid0", rvalid0, 1'b0);
    chk("rst_rvalid1", rvalid1, 1'b0);
    chk("rst_rom_addr", rom_addr, 11'h0);
    chk("rst_rdata0", rdata0, 8'h0);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic r0; logic [10:0] a0; logic r1; logic [10:0] a1; logic g0; logic g1;
  } vec_t;
  vec_t tbl [12];

  initial begin
    logic g0, g1, p0, p1;
    logic [10:0] ra0, ra1;
    rst = 1'b1;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;
    b_req0 = 0; b_req1 = 0; b_addr0 = 0; b_addr1 = 0;
    m_rd0 = 0; m_rd1 = 0; m_addr = 0;
    for (int i = 0; i < 12; i++)
      tbl[i] = '{1'b1, 11'h100 + 11'(i), 1'b1, 11'h600 + 11'(i / 4), (i % 4) != 3, (i % 4) == 3};
    repeat (3) @(negedge clk);
    rst = 1'b0;

    idle(20);

    // Single port-0 read of 'A' line 0
    step(1'b1, 11'h410, 1'b0, 11'h0, g0, g1);
    idle(2);
    chk("A_rvalid0", rvalid0, 1'b0);
    idle(1);
    chk("A_rdata0_seen", m_rd0, 8'h18);
    idle(2);

    // Sustained contention: port 1 forced through every fourth cycle
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].r0, tbl[i].a0, tbl[i].r1, tbl[i].a1, g0, g1);
      chk("tbl_gnt0", gnt0, tbl[i].g0);
      chk("tbl_gnt1", gnt1, tbl[i].g1);
    end
    idle(4);

    // Alternating ports back to back
    step(1'b1, 11'h041, 1'b0, 11'h0,   g0, g1);
    step(1'b0, 11'h0,   1'b1, 11'h7A2, g0, g1);
    step(1'b1, 11'h053, 1'b0, 11'h0,   g0, g1);
    step(1'b0, 11'h0,   1'b1, 11'h3C4, g0, g1);
    idle(5);

    // Reset while two reads are in flight
    step(1'b1, 11'h155, 1'b0, 11'h0,   g0, g1);
    step(1'b0, 11'h0,   1'b1, 11'h2AA, g0, g1);
    do_reset();
    idle(8);
    chk("post_rst_rdata1", rdata1, 8'h0);

    // Random traffic honouring hold-until-granted
    p0 = 0; p1 = 0; ra0 = 0; ra1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && ($urandom_range(0, 1) == 1)) begin p0 = 1; ra0 = 11'($urandom); end
      if (!p1 && ($urandom_range(0, 2) != 0)) begin p1 = 1; ra1 = 11'($urandom); end
      step(p0, ra0, p1, ra1, g0, g1);
      if (g0) p0 = 0;
      if (g1) p1 = 0;
    end
    idle(5);

    // ROM_LAT=4 build: single port-1 read returns six cycles after grant
    @(negedge clk);
    b_req1 = 1'b1; b_addr1 = 11'h2A5;
    #1;
    chk("b_gnt1", b_gnt1, 1'b1);
    chk("b_gnt0", b_gnt0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      b_req1 = 1'b0;
      #1;
      chk("b_rvalid1", b_rvalid1, k == 6);
      chk("b_rvalid0", b_rvalid0, 1'b0);
      if (k == 6) chk("b_rdata1", b_rdata1, romf(11'h2A5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/font_rom_arbiter.md
Name: font_rom_arbiter

Overview:
- Shares the single synchronous font ROM between two requesters.
  - Port 0: the board-label character generator (file/rank letters). High priority; pixel-locked.
  - Port 1: the status/text overlay (move list, clocks). Low priority; latency-tolerant.
- Selects one address per cycle and drives the ROM address.
- Tracks in-flight reads in a tag pipeline and returns each font line to the requester that issued it.
- Sits between the letter/text generators and the font ROM, ahead of the pixel-mux stage.

Parameters:
- ADDR_W, 11, font ROM address width ({char_code[6:0], line[3:0]}).
- DATA_W, 8, font line width (one bit per pixel).
- ROM_LAT, 1, clock edges from rom_addr change to valid rom_data. Legal range 1..4.
- MAX_WAIT, 3, consecutive denied cycles of req1 before port 1 is forced through. Legal range 1..15.

Ports:
- clk  in  1  system pixel clock
- rst  in  1  asynchronous, active-high reset
- req0  in  1  port 0 read request
- addr0  in  ADDR_W  port 0 font address
- gnt0  out  1  port 0 grant (combinational, same cycle)
- rvalid0  out  1  port 0 read-data valid pulse
- rdata0  out  DATA_W  port 0 font line
- req1  in  1  port 1 read request
- addr1  in  ADDR_W  port 1 font address
- gnt1  out  1  port 1 grant (combinational, same cycle)
- rvalid1  out  1  port 1 read-data valid pulse
- rdata1  out  DATA_W  port 1 font line
- rom_addr  out  ADDR_W  registered address to font ROM
- rom_data  in  DATA_W  font ROM output

Behaviour:
- Reset (async, active-high):
  - rom_addr=0, rvalid0/1=0, rdata0/1=0.
  - wait_cnt=0; all tag stages invalid.
  - In-flight reads are discarded; no rvalid is produced for them after reset is released.
- Handshake:
  - A transfer occurs in any cycle where reqN&gntN=1.
  - A requester holds reqN and addrN stable until granted.
  - The arbiter never asserts gntN without reqN.
- Arbitration, per cycle:
  - force1 = req1 & (wait_cnt >= MAX_WAIT).
  - force1 → gnt1=1, gnt0=0.
  - else req0 → gnt0=1.
  - else req1 → gnt1=1.
  - At most one grant per cycle.
- wait_cnt (4-bit):
  - Clears when gnt1 or !req1.
  - Increments when req1&!gnt1.
  - Saturates at 15.
- Address stage:
  - On any grant, rom_addr <= the granted address at the next edge.
  - With no grant, rom_addr holds its value.
- Tag pipeline:
  - Depth ROM_LAT+1; each stage holds {valid, id}.
  - Stage 0 loads {|gnt, gnt1} at the grant edge; stages shift every cycle.
  - When the last stage is valid, rom_data is captured into rdata[id] and rvalid[id] pulses for one cycle.
  - The other port's rdata holds its value (sticky); its rvalid stays 0.
- Latency:
  - Grant in cycle t → rvalid in cycle t+ROM_LAT+2 (3 cycles at default).
  - Fully pipelined: one result per cycle sustained; no bubbles on back-to-back grants, including alternating ports.
- Boundaries:
  - Simultaneous req0&req1 with wait_cnt < MAX_WAIT: port 0 wins; wait_cnt increments.
  - Continuous req0 plus req1: port 1 is granted every MAX_WAIT+1 cycles.
  - Reset asserted mid-flight: all pending tags are cleared immediately.

Decomposition:
- vga_pkg additions:
  - FONT_ADDR_W=11, FONT_DATA_W=8.
  - typedef struct packed {logic valid; logic id;} font_tag_t.
- One sub-module: font_tag_pipe.
  - Parameterised font_tag_t delay line of depth ROM_LAT+1 with async clear.
  - Keeps the arbiter top free of latency bookkeeping.

Test Plan:
- Reset then idle, no requests → all outputs 0, rom_addr=0, no rvalid for 20 cycles.
- Single req0, addr0=0x410 ('A' line 0), ROM model returns 0x18 → gnt0 same cycle, rom_addr=0x410 next cycle, rvalid0=1 with rdata0=0x18 exactly 3 cycles after grant; rvalid1 stays 0.
- req0 held high 12 cycles plus req1 held high (MAX_WAIT=3) → gnt1 asserted on cycles 3, 7, 11 (0-based); gnt0 on all others; wait_cnt clears after each gnt1.
- Alternating grants 0,1,0,1 with distinct addresses → rvalid0/rvalid1 alternate in consecutive cycles, each rdata matching its own address, zero bubbles.
- Grant two reads, assert rst one cycle later for one cycle → no rvalid after reset release; rdata0/1=0.
- ROM_LAT=4 build, single req1 → rvalid1 exactly 6 cycles after gnt1.
